// File: rtl/dmem_dma_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dmem_dma_ctrl                                                  |
// | Purpose  : Single-port controller in front of the data memory. Muxes     |
// |            CPU load/store traffic with a block engine doing byte copy    |
// |            and fill. The CPU always wins the port; the engine freezes    |
// |            on any cycle the CPU uses it.                                  |
// | Ports    : Clk, Reset (sync, active-high)                                 |
// |            Start/Mode/SrcAddr/DstAddr/Len/FillVal - block op launch      |
// |            CpuReq/CpuWrite/CpuAddr/CpuDataIn/CpuDataOut - CPU side       |
// |            MemDataOut/MemWrite/DataAddress/DataIn - memory side          |
// |            Busy (engine in READ/WRITE), Done (one-cycle completion)      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module dmem_dma_ctrl #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Mode,
  input  logic [AW-1:0] SrcAddr,
  input  logic [AW-1:0] DstAddr,
  input  logic [AW-1:0] Len,
  input  logic [DW-1:0] FillVal,
  input  logic          CpuReq,
  input  logic          CpuWrite,
  input  logic [AW-1:0] CpuAddr,
  input  logic [DW-1:0] CpuDataIn,
  input  logic [DW-1:0] MemDataOut,
  output logic          MemWrite,
  output logic [AW-1:0] DataAddress,
  output logic [DW-1:0] DataIn,
  output logic [DW-1:0] CpuDataOut,
  output logic          Busy,
  output logic          Done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [AW-1:0] count;
  logic [DW-1:0] buffer;
  logic [DW-1:0] fill_val;
  logic          mode;

  logic          stall;
  logic          eng_we;
  logic [AW-1:0] eng_addr;
  logic [DW-1:0] eng_data;

  // DONE is exempt from the CPU stall so the completion pulse is always
  // exactly one cycle wide; it does not use the memory port anyway.
  assign stall = CpuReq && (state != DONE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      src      <= '0;
      dst      <= '0;
      count    <= '0;
      buffer   <= '0;
      fill_val <= '0;
      mode     <= 1'b0;
    end else if (!stall) begin
      case (state)
        IDLE: begin
          if (Start) begin
            src      <= SrcAddr;
            dst      <= DstAddr;
            count    <= Len;
            fill_val <= FillVal;
            mode     <= Mode;
            if (Len == '0)
              state <= DONE;
            else if (Mode)
              state <= WRITE;
            else
              state <= READ;
          end
        end
        READ: begin
          buffer <= MemDataOut;
          state  <= WRITE;
        end
        WRITE: begin
          // Addresses wrap naturally at the register width.
          src   <= src + 1'b1;
          dst   <= dst + 1'b1;
          count <= count - 1'b1;
          if (count == AW'(1))
            state <= DONE;
          else if (mode)
            state <= WRITE;
          else
            state <= READ;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    eng_we   = 1'b0;
    eng_addr = '0;
    eng_data = '0;
    case (state)
      READ: eng_addr = src;
      WRITE: begin
        eng_addr = dst;
        eng_data = mode ? fill_val : buffer;
        // An abort via Reset must not land one more byte on that edge.
        eng_we   = ~Reset;
      end
      default: ;
    endcase
  end

  always_comb begin
    if (CpuReq) begin
      MemWrite    = CpuWrite;
      DataAddress = CpuAddr;
      DataIn      = CpuDataIn;
    end else begin
      MemWrite    = eng_we;
      DataAddress = eng_addr;
      DataIn      = eng_data;
    end
  end

  assign CpuDataOut = MemDataOut;
  assign Busy       = (state == READ) || (state == WRITE);
  assign Done       = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_dma_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_dmem_dma_ctrl                                               |
// | Purpose  : Self-checking bench for dmem_dma_ctrl with a 256x8 memory     |
// |            model, a byte-level reference of block operations, and a      |
// |            scoreboard for Done timing and CPU read data.                 |
// | Ports    : none                                                          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_dmem_dma_ctrl;

  logic       Clk = 1'b0;
  logic       Reset, Start, Mode, CpuReq, CpuWrite;
  logic [7:0] SrcAddr, DstAddr, Len, FillVal, CpuAddr, CpuDataIn;
  logic [7:0] MemDataOut, DataAddress, DataIn, CpuDataOut;
  logic       MemWrite, Busy, Done;

  dmem_dma_ctrl #(.AW(8), .DW(8)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Mode(Mode),
    .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Len(Len), .FillVal(FillVal),
    .CpuReq(CpuReq), .CpuWrite(CpuWrite), .CpuAddr(CpuAddr), .CpuDataIn(CpuDataIn),
    .MemDataOut(MemDataOut), .MemWrite(MemWrite), .DataAddress(DataAddress),
    .DataIn(DataIn), .CpuDataOut(CpuDataOut), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  // Memory attached to the controller: combinational read, synchronous write.
  logic [7:0] mem [0:255];
  always @(posedge Clk) if (MemWrite) mem[DataAddress] <= DataIn;
  assign MemDataOut = mem[DataAddress];

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] ref_mem [0:255];
  int         exp_done[$];
  logic [7:0] exp_rd[$];
  bit         req_pat [0:255];

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               nm, act, act, exp, exp, cyc);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (Done) begin
        if (exp_done.size() == 0) chk(1'b0, "unexpected_done", cyc, -1);
        else begin
          int e;
          e = exp_done.pop_front();
          chk(cyc == e, "done_cycle", cyc, e);
        end
      end
      if (CpuReq && !CpuWrite) begin
        if (exp_rd.size() == 0) chk(1'b0, "unexpected_cpu_read", int'(CpuDataOut), -1);
        else begin
          logic [7:0] e8;
          e8 = exp_rd.pop_front();
          chk(CpuDataOut === e8, "cpu_read_data", int'(CpuDataOut), int'(e8));
        end
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    CpuReq = 1'b1; CpuWrite = 1'b1; CpuAddr = a; CpuDataIn = d;
    ref_mem[a] = d;
    step();
    CpuReq = 1'b0; CpuWrite = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] a);
    CpuReq = 1'b1; CpuWrite = 1'b0; CpuAddr = a;
    exp_rd.push_back(ref_mem[a]);
    step();
    CpuReq = 1'b0;
  endtask

  task automatic clear_pat();
    for (int i = 0; i < 256; i++) req_pat[i] = 1'b0;
  endtask

  task automatic rand_pat();
    for (int i = 0; i < 256; i++) req_pat[i] = (i < 150) && ($urandom_range(0, 3) == 0);
  endtask

  task automatic check_mem(input string nm);
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk(bad == 0, nm, bad, 0);
  endtask

  // Launch one block op with CpuReq following req_pat (index = cycles after
  // Start). The expected Done cycle is the first cycle after all 2N (copy)
  // or N (fill) CPU-free engine slots have been consumed.
  task automatic run_op(input bit m, input logic [7:0] s, input logic [7:0] d,
                        input logic [7:0] n, input logic [7:0] fv,
                        input bit rnd_cpu, input bit poke_start, input string nm);
    int work, rem, done_k, s_cyc;
    logic [7:0] ia;
    work = (n == 0) ? 0 : (m ? int'(n) : 2 * int'(n));
    done_k = 1; rem = work;
    while (rem > 0) begin
      if (!req_pat[done_k]) rem--;
      done_k++;
    end
    for (int i = 0; i < int'(n); i++) begin
      ia = d + 8'(i);
      ref_mem[ia] = m ? fv : ref_mem[8'(s + 8'(i))];
    end
    Start = 1'b1; Mode = m; SrcAddr = s; DstAddr = d; Len = n; FillVal = fv;
    CpuReq = 1'b0; CpuWrite = 1'b0;
    s_cyc = cyc;
    exp_done.push_back(s_cyc + done_k);
    step();
    Start = 1'b0;
    for (int k = 1; k <= done_k + 1; k++) begin
      // A second Start while busy with different operands must be ignored.
      if (poke_start && k == 2 && work >= 2) begin
        Start = 1'b1; Mode = ~m; Len = 8'd1; DstAddr = 8'hB0; FillVal = 8'hEE;
      end else Start = 1'b0;
      CpuReq = req_pat[k];
      CpuWrite = 1'b0;
      if (req_pat[k]) begin
        if (rnd_cpu) begin
          CpuAddr = 8'hC0 | 8'($urandom_range(0, 63));
          CpuWrite = $urandom_range(0, 1) == 1;
          CpuDataIn = 8'($urandom);
          if (CpuWrite) ref_mem[CpuAddr] = CpuDataIn;
          else exp_rd.push_back(ref_mem[CpuAddr]);
        end else begin
          CpuAddr = 8'h80; CpuWrite = 1'b1; CpuDataIn = 8'h5A;
          ref_mem[8'h80] = 8'h5A;
        end
      end
      step();
    end
    Start = 1'b0; CpuReq = 1'b0; CpuWrite = 1'b0;
    @(negedge Clk);
    chk(exp_done.size() == 0, {nm, "_done_seen"}, exp_done.size(), 0);
    exp_done.delete();
    chk(Busy == 1'b0, {nm, "_busy_after"}, int'(Busy), 0);
    check_mem({nm, "_mem"});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_cyc;
    Reset = 1'b1; Start = 1'b0; Mode = 1'b0; SrcAddr = '0; DstAddr = '0; Len = '0;
    FillVal = '0; CpuReq = 1'b0; CpuWrite = 1'b0; CpuAddr = '0; CpuDataIn = '0;
    step(); step();
    Reset = 1'b0;
    @(negedge Clk);
    chk(Busy == 1'b0, "reset_busy", int'(Busy), 0);
    chk(Done == 1'b0, "reset_done", int'(Done), 0);
    chk(MemWrite == 1'b0 && DataAddress == 8'h00 && DataIn == 8'h00,
        "reset_port_idle", {MemWrite, DataAddress, DataIn}, 0);

    for (int i = 0; i < 256; i++) cpu_write(8'(i), 8'($urandom));
    check_mem("preload_mem");

    // Fill 0x10..0x13 with 0xA5, then read back through the CPU port.
    clear_pat();
    run_op(1'b1, 8'h00, 8'h10, 8'd4, 8'hA5, 1'b0, 1'b0, "fill");
    for (int i = 0; i < 4; i++) cpu_read(8'h10 + 8'(i));

    // Copy 1,2,3 from 0x20 to 0x40.
    cpu_write(8'h20, 8'd1); cpu_write(8'h21, 8'd2); cpu_write(8'h22, 8'd3);
    run_op(1'b0, 8'h20, 8'h40, 8'd3, 8'h00, 1'b0, 1'b0, "copy");

    // Same copy with the CPU writing 0x5A to 0x80 on cycles 2..4.
    for (int i = 0; i < 3; i++) ref_mem[8'h40 + 8'(i)] = 8'hFF;
    for (int i = 0; i < 3; i++) cpu_write(8'h40 + 8'(i), 8'hFF);
    clear_pat();
    req_pat[2] = 1'b1; req_pat[3] = 1'b1; req_pat[4] = 1'b1;
    run_op(1'b0, 8'h20, 8'h40, 8'd3, 8'h00, 1'b0, 1'b0, "contend");

    clear_pat();
    run_op(1'b1, 8'h00, 8'hFE, 8'd4, 8'h11, 1'b0, 1'b0, "wrap");
    run_op(1'b1, 8'h00, 8'h50, 8'd0, 8'h33, 1'b0, 1'b0, "len0");
    run_op(1'b0, 8'h30, 8'h31, 8'd5, 8'h00, 1'b0, 1'b1, "overlap");
    run_op(1'b1, 8'h00, 8'h70, 8'd6, 8'h6C, 1'b0, 1'b1, "busy_start");

    // Reset on the fourth WRITE cycle of an 8-byte fill: only 3 bytes land.
    Start = 1'b1; Mode = 1'b1; DstAddr = 8'h60; Len = 8'd8; FillVal = 8'h77;
    s_cyc = cyc;
    step();
    Start = 1'b0;
    step(); step(); step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) ref_mem[8'h60 + 8'(i)] = 8'h77;
    @(negedge Clk);
    chk(Busy == 1'b0 && Done == 1'b0, "abort_idle", {Busy, Done}, 0);
    check_mem("abort_mem");
    step();
    run_op(1'b1, 8'h00, 8'h90, 8'd3, 8'h42, 1'b0, 1'b0, "post_reset");

    for (int t = 0; t < 12; t++) begin
      rand_pat();
      run_op($urandom_range(0, 1) == 1, 8'($urandom_range(0, 159)), 8'($urandom_range(0, 159)),
             8'($urandom_range(0, 31)), 8'($urandom), 1'b1, $urandom_range(0, 1) == 1, "rand");
    end

    chk(exp_rd.size() == 0, "cpu_reads_drained", exp_rd.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_dma_ctrl.md
Name: dmem_dma_ctrl

Overview:
- Single-port controller in front of the 256x8 data memory. Combinational read, synchronous write.
- Arbitrates between CPU load/store traffic and a built-in block engine that performs byte copy and fill.
- The CPU always has priority; the engine yields the port on any cycle the CPU requests it.
- Sits between the CPU datapath and the data memory, and drives the memory's MemWrite, DataAddress and DataIn.

Parameters:
- AW, 8, address width; memory depth is 2**AW.
- DW, 8, data width.

Ports:
- Clk  in  1  clock
- Reset  in  1  reset
- Start  in  1  one-cycle request to launch a block operation
- Mode  in  1  0 = copy, 1 = fill
- SrcAddr  in  AW  copy source base
- DstAddr  in  AW  destination base
- Len  in  AW  byte count; 0 = no-op
- FillVal  in  DW  fill byte
- CpuReq  in  1  CPU wants the memory port this cycle
- CpuWrite  in  1  CPU write enable, qualified by CpuReq
- CpuAddr  in  AW  CPU address
- CpuDataIn  in  DW  CPU write data
- MemDataOut  in  DW  memory read data, combinational from DataAddress
- MemWrite  out  1  to memory
- DataAddress  out  AW  to memory
- DataIn  out  DW  to memory
- CpuDataOut  out  DW  equals MemDataOut
- Busy  out  1  engine active
- Done  out  1  one-cycle completion pulse

Behaviour:
- Clock and reset: clock Clk; reset Reset, synchronous, active-high.
- Reset forces state IDLE and clears src/dst/count/buffer registers to 0. Busy=0, Done=0.
- Reset mid-operation aborts the operation with no further writes; bytes already written stay in memory.
- Port mux, CPU owns the port: when CpuReq=1 (any state), DataAddress=CpuAddr, DataIn=CpuDataIn, MemWrite=CpuWrite. The engine holds all of its registers that cycle.
- Port mux, engine owns the port: when CpuReq=0, the engine drives the port per its state. In IDLE/DONE the engine drives MemWrite=0, DataAddress=0, DataIn=0.
- State machine: IDLE, READ, WRITE, DONE.
- IDLE: Start=1 captures SrcAddr, DstAddr, Len, FillVal and Mode.
  - Len=0: go to DONE.
  - Mode=0 (copy): go to READ.
  - Mode=1 (fill): go to WRITE.
  - Start is ignored in every state other than IDLE.
- READ (copy only), on a non-stalled cycle: DataAddress=src, MemWrite=0. At the clock edge, buffer<=MemDataOut and state goes to WRITE.
- WRITE, on a non-stalled cycle:
  - DataAddress=dst; DataIn=buffer (copy) or FillVal (fill); MemWrite=1.
  - At the edge: src+=1, dst+=1, count-=1.
  - If count was 1, go to DONE; otherwise go to READ (copy) or stay in WRITE (fill).
- DONE: Done=1 for exactly one cycle, then IDLE. Busy=1 in READ and WRITE, 0 otherwise.
- Address arithmetic is mod 2**AW. A block crossing 255 wraps to 0.
- Overlapping copy ranges: copy proceeds strictly ascending, byte by byte. dst = src+1 therefore replicates the first byte; this behaviour is required.
- Latency, uncontended: Done is high on cycle 2N+1 after the Start cycle for copy, N+1 for fill, and 1 for Len=0.
- Latency, contended: each cycle with CpuReq=1 during READ/WRITE adds exactly one cycle.
- CPU read data is always valid combinationally via CpuDataOut.

Test Plan:
- Fill: Reset; Start with Mode=1, DstAddr=0x10, Len=4, FillVal=0xA5, CpuReq=0 -> MemWrite high on 4 consecutive cycles at 0x10..0x13, Done on cycle 5, Busy=0 after; CPU reads of 0x10..0x13 return 0xA5.
- Copy: preload 0x20..0x22 = 1,2,3; Start with Mode=0, SrcAddr=0x20, DstAddr=0x40, Len=3 -> alternating read/write cycles, Done on cycle 7, 0x40..0x42 = 1,2,3.
- Contention: same copy with CpuReq=1, CpuWrite=1, CpuAddr=0x80, CpuDataIn=0x5A held for 3 cycles starting cycle 2 -> CPU write lands at 0x80, engine stalls, Done on cycle 10, copy data still correct.
- Wrap: fill DstAddr=0xFE, Len=4, FillVal=0x11 -> writes 0xFE, 0xFF, 0x00, 0x01; no other address touched.
- Edge cases: Len=0 -> Done on cycle 1 with zero writes. Start asserted while Busy -> ignored, no second Done.
- Reset: Reset during WRITE of a Len=8 fill after 3 writes -> Busy=0 and Done=0 next cycle; only 3 bytes written; subsequent Start works normally.
